// File: rtl/mem_cmd_issuer.sv
// mem_cmd_issuer
//
// Turns single user requests into byte packets on the command FIFO that feeds
// mem_controller, and hands the read data that comes back on the response
// FIFO to a consumer.
//
// Packet format (one byte per push):
//   write : 49 ('1'), address, data
//   read  : 48 ('0'), address
//
// Handshake semantics (all interfaces, sampled on the rising edge of clk):
//   A transfer happens on an edge where valid && ready are both 1. Valid is
//   held, with its payload stable, until that edge; ready may change at any
//   time and may depend combinationally on the partner's inputs.
//   The FIFO sides use flag semantics instead: a push happens on every edge
//   where cmd_fifo_wr_en is 1, a pop on every edge where resp_fifo_rd_en is
//   1, and the popped byte appears on resp_fifo_dout one cycle later.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       user request handshake
//   req_we, req_addr, req_data request payload (data ignored for reads)
//   cmd_fifo_full             command FIFO full flag
//   cmd_fifo_wr_en/din        command FIFO push and byte
//   resp_fifo_empty           response FIFO empty flag
//   resp_fifo_rd_en/dout      response FIFO pop and byte (dout one cycle late)
//   resp_valid/ready, data    read data handshake towards the consumer
//   outstanding               reads issued and not yet handed to the consumer
//   err_unexpected            sticky: response byte arrived with nothing owed
//   dbg_state                 current command FSM state (debug observation)

module mem_cmd_issuer #(
  parameter int FIFO_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [FIFO_WIDTH-1:0] req_addr,
  input  logic [FIFO_WIDTH-1:0] req_data,

  input  logic                  cmd_fifo_full,
  output logic                  cmd_fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] cmd_fifo_din,

  input  logic                  resp_fifo_empty,
  output logic                  resp_fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] resp_fifo_dout,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [FIFO_WIDTH-1:0] resp_data,

  output logic [OUT_W-1:0]      outstanding,
  output logic                  err_unexpected,
  output logic [1:0]            dbg_state
);

  localparam logic [FIFO_WIDTH-1:0] CMD_WRITE = FIFO_WIDTH'(49);
  localparam logic [FIFO_WIDTH-1:0] CMD_READ  = FIFO_WIDTH'(48);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_CMD  = 2'd1,
    SEND_ADDR = 2'd2,
    SEND_DATA = 2'd3
  } cmd_state_t;

  cmd_state_t state_q;
  cmd_state_t state_d;

  // Request captured at acceptance; the packet is built from these so the
  // user side is free as soon as the request is taken.
  logic                  lat_we;
  logic [FIFO_WIDTH-1:0] lat_addr;
  logic [FIFO_WIDTH-1:0] lat_data;

  logic accept;
  logic out_full;
  logic read_addr_push;
  logic resp_take;
  logic rd_pending;

  assign dbg_state = state_q;

  // A read may only be taken while there is room to count it.
  assign out_full = (outstanding == OUT_W'(MAX_OUTSTANDING));

  // ---------------------------------------------------------------------------
  // Command FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    cmd_fifo_wr_en = 1'b0;
    cmd_fifo_din   = '0;

    case (state_q)
      IDLE: begin
        req_ready = !rst && (req_we || !out_full);
        if (req_valid && req_ready) begin
          state_d = SEND_CMD;
        end
      end

      SEND_CMD: begin
        cmd_fifo_din   = lat_we ? CMD_WRITE : CMD_READ;
        cmd_fifo_wr_en = !cmd_fifo_full && !rst;
        if (cmd_fifo_wr_en) begin
          state_d = SEND_ADDR;
        end
      end

      SEND_ADDR: begin
        cmd_fifo_din   = lat_addr;
        cmd_fifo_wr_en = !cmd_fifo_full && !rst;
        if (cmd_fifo_wr_en) begin
          state_d = lat_we ? SEND_DATA : IDLE;
        end
      end

      SEND_DATA: begin
        cmd_fifo_din   = lat_data;
        cmd_fifo_wr_en = !cmd_fifo_full && !rst;
        if (cmd_fifo_wr_en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_ready is only ever raised in IDLE, so this is the IDLE acceptance.
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_we   <= req_we;
      lat_addr <= req_addr;
      lat_data <= req_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-read counter
  // ---------------------------------------------------------------------------
  // A read becomes owed when its address byte leaves, since that is the byte
  // that completes the packet for mem_controller.
  assign read_addr_push = cmd_fifo_wr_en && (state_q == SEND_ADDR) && !lat_we;
  assign resp_take      = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (read_addr_push && !resp_take) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!read_addr_push && resp_take && (outstanding != '0)) begin
      // Hand-offs of unsolicited bytes must not wrap the count below zero.
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  // Only one byte is ever in flight between the FIFO and resp_data, so no
  // skid storage is needed: pop, wait one cycle for dout, capture, present.
  assign resp_fifo_rd_en = !rst && !resp_fifo_empty && !rd_pending && !resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending     <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      rd_pending <= resp_fifo_rd_en;
      if (rd_pending) begin
        // rd_pending implies resp_valid was low, so no handshake collides.
        resp_data  <= resp_fifo_dout;
        resp_valid <= 1'b1;
        if (outstanding == '0) begin
          err_unexpected <= 1'b1;
        end
      end else if (resp_take) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Bench for mem_cmd_issuer: directed requests, a byte-level mem_controller
// stand-in on the two FIFOs, and a per-cycle compare against a transaction
// model (expected byte stream, expected read data, outstanding count).

module tb_mem_cmd_issuer;

  localparam int W    = 8;
  localparam int MAXO = 8;
  localparam int OW   = $clog2(MAXO + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [W-1:0]  req_addr = '0;
  logic [W-1:0]  req_data = '0;
  logic          cmd_fifo_full = 1'b0;
  logic          cmd_fifo_wr_en;
  logic [W-1:0]  cmd_fifo_din;
  logic          resp_fifo_empty = 1'b1;
  logic          resp_fifo_rd_en;
  logic [W-1:0]  resp_fifo_dout = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_data;
  logic [OW-1:0] outstanding;
  logic          err_unexpected;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_cmd_issuer #(.FIFO_WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .cmd_fifo_full   (cmd_fifo_full),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_din    (cmd_fifo_din),
    .resp_fifo_empty (resp_fifo_empty),
    .resp_fifo_rd_en (resp_fifo_rd_en),
    .resp_fifo_dout  (resp_fifo_dout),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .outstanding     (outstanding),
    .err_unexpected  (err_unexpected),
    .dbg_state       (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];       // expected command bytes, in push order
  logic         exp_rd_q[$];    // 1 = that byte is a read's address byte
  logic [W-1:0] resp_exp_q[$];  // expected read data, in hand-off order
  logic         resp_unexp_q[$];// 1 = byte was injected, nothing owed for it
  logic [W-1:0] shadow [256];   // what memory must hold after accepted writes
  int           model_out = 0;
  logic         err_model = 1'b0;

  // mem_controller stand-in
  logic [W-1:0] mc_mem [256];
  logic [W-1:0] resp_q[$];
  int           mc_phase = 0;
  logic         mc_we = 1'b0;
  logic [W-1:0] mc_addr = '0;
  logic         pop_req = 1'b0;
  logic         push_req = 1'b0;
  logic [W-1:0] push_byte = '0;
  logic         inject_valid = 1'b0;
  logic [W-1:0] inject_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: one sample per cycle on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    pop_req   = resp_fifo_rd_en;
    push_req  = cmd_fifo_wr_en;
    push_byte = cmd_fifo_din;
    if (rst) begin
      check("rst_cmd_wr_en", {31'b0, cmd_fifo_wr_en}, 0);
      check("rst_resp_rd_en", {31'b0, resp_fifo_rd_en}, 0);
      exp_q.delete();
      exp_rd_q.delete();
      resp_exp_q.delete();
      resp_unexp_q.delete();
      model_out = 0;
      err_model = 1'b0;
    end else begin
      if (resp_valid && resp_unexp_q.size() > 0 && resp_unexp_q[0]) err_model = 1'b1;
      check("outstanding", {{(32-OW){1'b0}}, outstanding}, model_out);
      check("err_unexpected", {31'b0, err_unexpected}, {31'b0, err_model});
      check("wr_en_while_full", {31'b0, cmd_fifo_wr_en & cmd_fifo_full}, 0);
      if (cmd_fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_extra_byte: got %0d expected no push", cmd_fifo_din);
        end else begin
          check("cmd_byte", {24'b0, cmd_fifo_din}, {24'b0, exp_q[0]});
          if (exp_rd_q[0]) model_out++;
          void'(exp_q.pop_front());
          void'(exp_rd_q.pop_front());
        end
      end
      if (resp_valid && resp_ready) begin
        if (resp_exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_extra: got %0d expected no response", resp_data);
        end else begin
          check("resp_data", {24'b0, resp_data}, {24'b0, resp_exp_q[0]});
          if (!resp_unexp_q[0] && model_out > 0) model_out--;
          void'(resp_exp_q.pop_front());
          void'(resp_unexp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFOs + mem_controller stand-in (acts on what was sampled at negedge)
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [W-1:0] tmp;
    if (pop_req && resp_q.size() > 0) begin
      tmp = resp_q.pop_front();
      resp_fifo_dout <= tmp;
    end
    if (rst) begin
      mc_phase = 0;
    end else if (push_req) begin
      case (mc_phase)
        0: begin
          mc_we    = (push_byte == 8'd49);
          mc_phase = 1;
        end
        1: begin
          mc_addr = push_byte;
          if (mc_we) begin
            mc_phase = 2;
          end else begin
            resp_q.push_back(mc_mem[push_byte]);
            mc_phase = 0;
          end
        end
        default: begin
          mc_mem[mc_addr] = push_byte;
          mc_phase = 0;
        end
      endcase
    end
    if (inject_valid) resp_q.push_back(inject_byte);
    resp_fifo_empty <= (resp_q.size() == 0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called and returning at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send_req(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back(we ? 8'd49 : 8'd48);
      exp_rd_q.push_back(1'b0);
      exp_q.push_back(a);
      exp_rd_q.push_back(!we);
      if (we) begin
        exp_q.push_back(d);
        exp_rd_q.push_back(1'b0);
        shadow[a] = d;
      end else begin
        resp_exp_q.push_back(shadow[a]);
        resp_unexp_q.push_back(1'b0);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mc_mem[i] = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {30'b0, dbg_state}, 0);
    check("reset_outstanding", {{(32-OW){1'b0}}, outstanding}, 0);
    check("reset_resp_valid", {31'b0, resp_valid}, 0);
    check("reset_resp_data", {24'b0, resp_data}, 0);
    check("reset_err", {31'b0, err_unexpected}, 0);
    check("reset_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;

    // Write addr=10 data=65, three consecutive pushes
    send_req(1'b1, 8'd10, 8'd65);
    @(negedge clk);
    check("wr_b0_en", {31'b0, cmd_fifo_wr_en}, 1);
    check("wr_b0", {24'b0, cmd_fifo_din}, 49);
    @(negedge clk);
    check("wr_b1", {24'b0, cmd_fifo_din}, 10);
    @(negedge clk);
    check("wr_b2", {24'b0, cmd_fifo_din}, 65);
    n = 0;
    while (mc_mem[10] !== 8'd65 && n < 10) begin
      @(posedge clk);
      n++;
    end
    check("mem10_written", {24'b0, mc_mem[10]}, 65);
    @(posedge clk); #1;

    // Read addr=10, response held then handed off
    send_req(1'b0, 8'd10, 8'd0);
    @(negedge clk);
    check("rd_b0", {24'b0, cmd_fifo_din}, 48);
    @(negedge clk);
    check("rd_b1", {24'b0, cmd_fifo_din}, 10);
    @(negedge clk);
    check("rd_outstanding_1", {{(32-OW){1'b0}}, outstanding}, 1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_resp_valid", {31'b0, resp_valid}, 1);
    check("rd_resp_data", {24'b0, resp_data}, 65);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check("rd_outstanding_0", {{(32-OW){1'b0}}, outstanding}, 0);
    check("rd_resp_cleared", {31'b0, resp_valid}, 0);
    @(posedge clk); #1;

    // Write addr=18 data=73 with the FIFO full for 5 cycles in SEND_ADDR
    send_req(1'b1, 8'd18, 8'd73);
    @(negedge clk);
    check("stall_b0", {24'b0, cmd_fifo_din}, 49);
    @(posedge clk); #1 cmd_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wr_en_low", {31'b0, cmd_fifo_wr_en}, 0);
      check("stall_din_held", {24'b0, cmd_fifo_din}, 18);
      @(posedge clk); #1;
    end
    cmd_fifo_full = 1'b0;
    @(negedge clk);
    check("stall_b1_en", {31'b0, cmd_fifo_wr_en}, 1);
    check("stall_b1", {24'b0, cmd_fifo_din}, 18);
    @(negedge clk);
    check("stall_b2", {24'b0, cmd_fifo_din}, 73);
    n = 0;
    while (mc_mem[18] !== 8'd73 && n < 10) begin
      @(posedge clk);
      n++;
    end
    check("mem18_written", {24'b0, mc_mem[18]}, 73);
    @(posedge clk); #1;

    // Eight reads fill the outstanding budget; the ninth must be held off
    resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_req(1'b0, 8'(i * 3 + 1), 8'd0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'd99;
    repeat (6) @(negedge clk);
    check("ninth_req_ready_low", {31'b0, req_ready}, 0);
    check("ninth_outstanding_8", {{(32-OW){1'b0}}, outstanding}, 8);
    check("ninth_state_idle", {30'b0, dbg_state}, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while (resp_exp_q.size() != 0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", resp_exp_q.size(), 0);
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check("drain_outstanding_0", {{(32-OW){1'b0}}, outstanding}, 0);
    @(posedge clk); #1;

    // Unsolicited response byte with nothing outstanding
    inject_byte  = 8'hC3;
    inject_valid = 1'b1;
    resp_exp_q.push_back(8'hC3);
    resp_unexp_q.push_back(1'b1);
    @(posedge clk); #1 inject_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("unexp_valid", {31'b0, resp_valid}, 1);
    check("unexp_data", {24'b0, resp_data}, 8'hC3);
    check("unexp_err", {31'b0, err_unexpected}, 1);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("unexp_err_sticky", {31'b0, err_unexpected}, 1);
    check("unexp_outstanding_0", {{(32-OW){1'b0}}, outstanding}, 0);
    @(posedge clk); #1;

    // Reset during SEND_ADDR of a write abandons the packet
    send_req(1'b1, 8'h20, 8'h33);
    @(negedge clk);
    check("abort_b0", {24'b0, cmd_fifo_din}, 49);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_no_push", {31'b0, cmd_fifo_wr_en}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_state", {30'b0, dbg_state}, 0);
    check("abort_outstanding", {{(32-OW){1'b0}}, outstanding}, 0);
    check("abort_resp_valid", {31'b0, resp_valid}, 0);
    check("abort_resp_data", {24'b0, resp_data}, 0);
    check("abort_err", {31'b0, err_unexpected}, 0);
    check("abort_wr_en", {31'b0, cmd_fifo_wr_en}, 0);
    check("abort_mem_untouched", {24'b0, mc_mem[8'h20]}, 8'h7A);
    @(posedge clk); #1;
    send_req(1'b1, 8'h21, 8'h44);
    n = 0;
    while (mc_mem[8'h21] !== 8'h44 && n < 10) begin
      @(posedge clk);
      n++;
    end
    check("post_reset_write", {24'b0, mc_mem[8'h21]}, 8'h44);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    send_req(1'b0, 8'h21, 8'd0);
    n = 0;
    while (resp_exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("post_reset_read_done", resp_exp_q.size(), 0);

    repeat (5) @(negedge clk);
    check("cmd_stream_drained", exp_q.size(), 0);
    check("resp_stream_drained", resp_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
